// File: rtl/keypad_scan.sv
// 4x4 active-low matrix keypad scanner with frame debounce and one-hot key output.
// Optional auto-repeat of key_press is built when KEYPAD_REPEAT_EN is defined.
module keypad_scan #(
  parameter int CLK_DIV       = 50000,
  parameter int DEBOUNCE      = 4,
  parameter int REPEAT_FRAMES = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row_in,
  output logic [3:0]  col_out,
  output logic [15:0] onehot,
  output logic        key_valid,
  output logic        key_press
);

  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [CNT_W-1:0] DEB_MAX  = CNT_W'(DEBOUNCE);

  typedef enum logic [1:0] {COL0, COL1, COL2, COL3} state_t;

  state_t            state_reg, state_next;
  logic [3:0]        col_reg, col_next;
  logic [3:0]        row_meta_reg, row_sync_reg;
  logic [DIV_W-1:0]  div_reg;
  logic              tick;
  logic [15:0]       raw;
  logic              frame_done_reg;
  logic [15:0]       last_frame_reg;
  logic [CNT_W-1:0]  stable_cnt_reg, stable_cnt_next;
  logic [15:0]       onehot_reg, onehot_next;
  logic              key_valid_reg, key_valid_next;
  logic              key_press_reg, key_press_next;
  logic              same, saturated, accept, single_key;

  // Rows are asynchronous to clk; idle level is high (no key).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      row_meta_reg <= 4'hF;
      row_sync_reg <= 4'hF;
    end else begin
      row_meta_reg <= row_in;
      row_sync_reg <= row_meta_reg;
    end
  end

  assign tick = (div_reg == DIV_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) div_reg <= '0;
    else        div_reg <= tick ? '0 : div_reg + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= COL0;
      col_reg   <= 4'b1110;
    end else begin
      state_reg <= state_next;
      col_reg   <= col_next;
    end
  end

  // Column drive is registered from the next state so the pins never glitch.
  always_comb begin
    state_next = state_reg;
    if (tick) begin
      case (state_reg)
        COL0:    state_next = COL1;
        COL1:    state_next = COL2;
        COL2:    state_next = COL3;
        default: state_next = COL0;
      endcase
    end
    col_next = 4'b1111;
    col_next[state_next] = 1'b0;
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_col
    logic [3:0] samp_reg;
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                                    samp_reg <= '0;
      else if (tick && state_reg == state_t'(gi))    samp_reg <= ~row_sync_reg;
    end
    assign raw[4*gi +: 4] = samp_reg;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) frame_done_reg <= 1'b0;
    else        frame_done_reg <= tick && (state_reg == COL3);
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_W = $clog2(REPEAT_FRAMES + 1);
  logic [REP_W-1:0] rep_cnt_reg, rep_cnt_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rep_cnt_reg <= '0;
    else        rep_cnt_reg <= rep_cnt_next;
  end
`endif

  always_comb begin
    same            = (raw == last_frame_reg);
    saturated       = (stable_cnt_reg == DEB_MAX);
    single_key      = (raw != 16'h0) && ((raw & (raw - 16'd1)) == 16'h0);
    stable_cnt_next = stable_cnt_reg;
    onehot_next     = onehot_reg;
    key_valid_next  = key_valid_reg;
    key_press_next  = 1'b0;
    if (frame_done_reg) begin
      if (!same)           stable_cnt_next = CNT_W'(1);
      else if (!saturated) stable_cnt_next = stable_cnt_reg + 1'b1;
    end
    // Accept only on the transition into DEBOUNCE, never while already saturated.
    accept = frame_done_reg && (stable_cnt_next == DEB_MAX) && !(same && saturated);
    if (accept) begin
      if (single_key) begin
        onehot_next    = raw;
        key_valid_next = 1'b1;
        key_press_next = (raw != onehot_reg);
      end else if (raw == 16'h0) begin
        onehot_next    = 16'h0;
        key_valid_next = 1'b0;
      end
    end
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_next = rep_cnt_reg;
    if (frame_done_reg) begin
      if (accept) begin
        rep_cnt_next = '0;
      end else if (key_valid_reg && same && saturated && raw == onehot_reg) begin
        if (rep_cnt_reg == REP_W'(REPEAT_FRAMES - 1)) begin
          rep_cnt_next   = '0;
          key_press_next = 1'b1;
        end else begin
          rep_cnt_next = rep_cnt_reg + 1'b1;
        end
      end else begin
        rep_cnt_next = '0;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_frame_reg <= '0;
      stable_cnt_reg <= '0;
      onehot_reg     <= '0;
      key_valid_reg  <= 1'b0;
      key_press_reg  <= 1'b0;
    end else begin
      if (frame_done_reg && !same) last_frame_reg <= raw;
      stable_cnt_reg <= stable_cnt_next;
      onehot_reg     <= onehot_next;
      key_valid_reg  <= key_valid_next;
      key_press_reg  <= key_press_next;
    end
  end

  assign col_out   = col_reg;
  assign onehot    = onehot_reg;
  assign key_valid = key_valid_reg;
  assign key_press = key_press_reg;

endmodule

// File: doc/keypad_scan.md
Name: keypad_scan

Overview:
- Scans a 4x4 active-low matrix keypad: drives columns one at a time, samples rows, debounces a full 16-key frame.
- Presents the accepted key as a one-hot word plus a valid level and a one-cycle press strobe.
- Sits upstream of the one-hot-to-digit encoder in the display path and produces the one-hot word that encoder consumes.

Parameters:
- CLK_DIV, 50000: clk cycles per column step (column settle time); legal range >= 4.
- DEBOUNCE, 4: number of consecutive identical frames required to accept a frame; legal range >= 1.
- REPEAT_FRAMES, 32: auto-repeat period in frames; used only with KEYPAD_REPEAT_EN.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- row_in  input  4  keypad rows, active-low (external pull-ups); asynchronous to clk
- col_out  output  4  column drive, active-low, exactly one bit low at any time
- onehot  output  16  accepted key, bit index = 4*col + row; 0 when no key
- key_valid  output  1  high while onehot is non-zero
- key_press  output  1  one-cycle strobe when a new key is accepted

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low. All state clears immediately on rst_n low, independent of clk.
- Reset values:
  - col_out = 4'b1110 (column 0 driven).
  - onehot = 0, key_valid = 0, key_press = 0.
  - Divider, column index, frame registers and stable counter = 0.
- Input synchronisation: row_in passes through a 2-flop synchroniser before any use.
- Divider: counts 0..CLK_DIV-1; tick when the count equals CLK_DIV-1, then it wraps to 0.
- Scan FSM:
  - States: COL0 -> COL1 -> COL2 -> COL3 -> COL0, advancing only on tick.
  - In state COLc, col_out has bit c low and all other bits high.
  - On tick, raw[4*c+r] <= ~row_sync[r] for r = 0..3, then the FSM advances. The column is therefore driven a full CLK_DIV cycles before it is sampled.
  - Sampling COL3 completes a frame (frame_done, one cycle); frame period = 4*CLK_DIV cycles.
- Debounce, on frame_done:
  - If raw == last_frame: stable_cnt increments, saturating at DEBOUNCE.
  - Otherwise: last_frame <= raw and stable_cnt <= 1.
  - The frame is accepted in the cycle stable_cnt first reaches DEBOUNCE. A frame is not re-accepted while it stays stable.
- Accepted frame handling:
  - Exactly one bit set: onehot <= frame, key_valid <= 1. key_press pulses in the same cycle onehot changes, only if the new value differs from the old one.
  - Zero bits set: onehot <= 0, key_valid <= 0, no pulse.
  - Two or more bits set (ghosting / multi-press): ignored. onehot and key_valid hold their previous values, no pulse.
- Latency: from row_in stable to onehot update is at most (DEBOUNCE+1) frames + 3 cycles.
- Boundary conditions:
  - A bounce in any frame restarts the debounce count.
  - A key change from A directly to B (stable) updates onehot to B and pulses key_press.
  - A press shorter than DEBOUNCE frames produces no output change.
  - rst_n asserted mid-scan aborts the frame; scanning resumes at COL0 with a fresh divider after rst_n deasserts.

Optional Feature:
- Macro: KEYPAD_REPEAT_EN.
- Defined: while key_valid is high and the same single-key frame stays stable, key_press re-pulses once every REPEAT_FRAMES frames after the initial press. The repeat counter clears on any change of onehot or on release.
- Undefined: exactly one key_press per accepted new key. The repeat counter is not built.

Test Plan (CLK_DIV=4, DEBOUNCE=2, frame = 16 cycles):
- Reset: rst_n low, then high -> col_out=1110, onehot=0, key_valid=0, key_press=0; col_out rotates 1110, 1101, 1011, 0111 every 4 cycles.
- Press col2/row1 (row_in[1]=0 whenever col_out[2]=0), held -> within 3 frames + 3 cycles onehot=16'h0200, key_valid=1; key_press high for exactly 1 cycle.
- Bounce: key present in alternate frames for 6 frames, then released -> onehot stays 0, no key_press.
- Hold 16'h0200, add col1/row3 -> onehot holds 16'h0200, no pulse. Release col2/row1 -> onehot=16'h0080 with one pulse.
- Release all keys -> onehot=0, key_valid=0 within 3 frames; no pulse.
- Assert rst_n mid-COL2 with a key held -> outputs clear asynchronously before the next clk edge; after release, re-acceptance takes the full DEBOUNCE frames. With KEYPAD_REPEAT_EN and REPEAT_FRAMES=4, a held key gives pulses 4 frames apart.
